// File: rtl/mux_bus_arbiter_pkg.sv
// Shared encodings for the datapath mux arbiter: FSM states, source indices and widths.
package mux_bus_arbiter_pkg;

  localparam int NUM_SRC = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [SEL_W-1:0] SRC_A = 2'd0;
  localparam logic [SEL_W-1:0] SRC_B = 2'd1;
  localparam logic [SEL_W-1:0] SRC_C = 2'd2;
  localparam logic [SEL_W-1:0] SRC_D = 2'd3;

  function automatic logic [NUM_SRC-1:0] onehot(input logic [SEL_W-1:0] idx);
    return NUM_SRC'(1) << idx;
  endfunction

endpackage

// File: rtl/mux_bus_arbiter_rr_pick4.sv
// Combinational round-robin search: first set req bit starting just after ptr, wrapping,
// ending on ptr itself.
module rr_pick4
  import mux_bus_arbiter_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   pick_idx,
  output logic               pick_valid
);

  logic [SEL_W-1:0] cand;

  // Walk from the farthest candidate back to the nearest so the nearest set bit wins.
  always_comb begin
    pick_idx   = SRC_A;
    pick_valid = 1'b0;
    cand       = SRC_A;
    for (int k = NUM_SRC; k >= 1; k--) begin
      cand = ptr + SEL_W'(k);
      if (req[cand]) begin
        pick_idx   = cand;
        pick_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_bus_arbiter.sv
// Round-robin owner sequencer for the shared 16-bit 4:1 datapath mux, with a bounded
// hold time per ownership and back-to-back handover.
//
// state    | meaning
// ST_IDLE  | no owner; grant=0, sel keeps the last owner index
// ST_GRANT | owner sel holds the bus; hold_cnt counts its granted cycles from 0
module mux_bus_arbiter
  import mux_bus_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] req,
  output logic [NUM_SRC-1:0] grant,
  output logic [SEL_W-1:0]   sel,
  output logic               bus_valid,
  output logic               owner_last
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] pick_ptr;
  logic [SEL_W-1:0] pick_idx;
  logic             pick_valid;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] hold_nxt;
  logic             release_now;

  // On handover the search starts after the current owner, which is the pointer-to-be.
  assign pick_ptr    = (state == ST_GRANT) ? sel : ptr;
  assign release_now = !req[sel] || (hold_cnt == HOLD_LAST);
  assign hold_nxt    = hold_cnt + CNT_W'(1);

  rr_pick4 u_pick (
    .req        (req),
    .ptr        (pick_ptr),
    .pick_idx   (pick_idx),
    .pick_valid (pick_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      ptr        <= SRC_D;
      hold_cnt   <= '0;
      grant      <= '0;
      sel        <= SRC_A;
      bus_valid  <= 1'b0;
      owner_last <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            state      <= ST_GRANT;
            grant      <= onehot(pick_idx);
            sel        <= pick_idx;
            bus_valid  <= 1'b1;
            hold_cnt   <= '0;
            owner_last <= (HOLD_LAST == '0);
          end
        end
        ST_GRANT: begin
          if (!release_now) begin
            hold_cnt   <= hold_nxt;
            owner_last <= (hold_nxt == HOLD_LAST);
          end else begin
            ptr      <= sel;
            hold_cnt <= '0;
            if (pick_valid) begin
              grant      <= onehot(pick_idx);
              sel        <= pick_idx;
              bus_valid  <= 1'b1;
              owner_last <= (HOLD_LAST == '0);
            end else begin
              state      <= ST_IDLE;
              grant      <= '0;
              bus_valid  <= 1'b0;
              owner_last <= 1'b0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_bus_arbiter.sv
// Bench for mux_bus_arbiter: three instances (MAX_HOLD 8, 2, 1) share stimulus and are checked
// against an owner/counter/pointer reference model, fixed vector tables and hand sequences.
module tb_mux_bus_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;

  logic [3:0] grant_o [3];
  logic [1:0] sel_o   [3];
  logic       bv_o    [3];
  logic       ol_o    [3];

  int mhv [3];
  int m_own [3];
  int m_cnt [3];
  int m_ptr [3];
  int m_sel [3];

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic [3:0] r;
    logic [3:0] g8;
    logic [3:0] g2;
    logic [1:0] s2;
    logic [3:0] g1;
  } vec_t;

  vec_t tbl [9];

  mux_bus_arbiter #(.MAX_HOLD(8), .CNT_W(8)) u_mh8 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .grant(grant_o[0]), .sel(sel_o[0]), .bus_valid(bv_o[0]), .owner_last(ol_o[0]));

  mux_bus_arbiter #(.MAX_HOLD(2), .CNT_W(2)) u_mh2 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .grant(grant_o[1]), .sel(sel_o[1]), .bus_valid(bv_o[1]), .owner_last(ol_o[1]));

  mux_bus_arbiter #(.MAX_HOLD(1), .CNT_W(1)) u_mh1 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .grant(grant_o[2]), .sel(sel_o[2]), .bus_valid(bv_o[2]), .owner_last(ol_o[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_own[i] = -1;
      m_cnt[i] = 0;
      m_ptr[i] = 3;
      m_sel[i] = 0;
    end
  endtask

  // Owner keeps the bus while it still requests and has hold budget left; otherwise the
  // search restarts one past the owner (or past the pointer when idle).
  task automatic model_step(input logic [3:0] r);
    bit keep;
    int c;
    for (int i = 0; i < 3; i++) begin
      keep = 1'b0;
      if (m_own[i] >= 0) begin
        if (r[m_own[i]] && m_cnt[i] < mhv[i] - 1) keep = 1'b1;
      end
      if (keep) begin
        m_cnt[i]++;
      end else begin
        if (m_own[i] >= 0) m_ptr[i] = m_own[i];
        m_own[i] = -1;
        m_cnt[i] = 0;
        for (int k = 1; k <= 4; k++) begin
          c = (m_ptr[i] + k) % 4;
          if (m_own[i] < 0 && r[c]) m_own[i] = c;
        end
        if (m_own[i] >= 0) m_sel[i] = m_own[i];
      end
    end
  endtask

  task automatic check_model();
    logic [3:0] eg;
    for (int i = 0; i < 3; i++) begin
      eg = (m_own[i] >= 0) ? (4'b0001 << m_own[i]) : 4'b0000;
      chk($sformatf("grant mh=%0d", mhv[i]), 32'(grant_o[i]), 32'(eg));
      chk($sformatf("sel mh=%0d", mhv[i]), 32'(sel_o[i]), 32'(m_sel[i][1:0]));
      chk($sformatf("bus_valid mh=%0d", mhv[i]), 32'(bv_o[i]), 32'(m_own[i] >= 0));
      chk($sformatf("owner_last mh=%0d", mhv[i]), 32'(ol_o[i]),
          32'(m_own[i] >= 0 && m_cnt[i] == mhv[i] - 1));
    end
  endtask

  task automatic step(input logic [3:0] r);
    req = r;
    @(posedge clk);
    #1;
    model_step(r);
    check_model();
  endtask

  task automatic do_reset();
    req   = 4'b0000;
    rst_n = 1'b0;
    model_reset();
    #2;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    mhv[0] = 8; mhv[1] = 2; mhv[2] = 1;
    rst_n = 1'b0;
    req   = 4'b0000;
    model_reset();

    tbl[0] = '{4'b1111, 4'b0001, 4'b0001, 2'd0, 4'b0001};
    tbl[1] = '{4'b1111, 4'b0001, 4'b0001, 2'd0, 4'b0010};
    tbl[2] = '{4'b1111, 4'b0001, 4'b0010, 2'd1, 4'b0100};
    tbl[3] = '{4'b1111, 4'b0001, 4'b0010, 2'd1, 4'b1000};
    tbl[4] = '{4'b1111, 4'b0001, 4'b0100, 2'd2, 4'b0001};
    tbl[5] = '{4'b1111, 4'b0001, 4'b0100, 2'd2, 4'b0010};
    tbl[6] = '{4'b1111, 4'b0001, 4'b1000, 2'd3, 4'b0100};
    tbl[7] = '{4'b1111, 4'b0001, 4'b1000, 2'd3, 4'b1000};
    tbl[8] = '{4'b1111, 4'b0010, 4'b0001, 2'd0, 4'b0001};

    // Reset state, then a lone requester on source 0.
    do_reset();
    #1;
    check_model();
    chk("reset grant", 32'(grant_o[0]), 32'h0);
    chk("reset sel", 32'(sel_o[0]), 32'h0);
    for (int k = 1; k <= 10; k++) begin
      step(4'b0001);
      chk($sformatf("solo grant c%0d", k), 32'(grant_o[0]), 32'h1);
      chk($sformatf("solo owner_last c%0d", k), 32'(ol_o[0]), 32'(k == 8));
    end

    // All sources requesting: fixed rotation tables per hold limit.
    do_reset();
    for (int k = 0; k < 9; k++) begin
      step(tbl[k].r);
      chk($sformatf("tbl g8 r%0d", k), 32'(grant_o[0]), 32'(tbl[k].g8));
      chk($sformatf("tbl g2 r%0d", k), 32'(grant_o[1]), 32'(tbl[k].g2));
      chk($sformatf("tbl s2 r%0d", k), 32'(sel_o[1]), 32'(tbl[k].s2));
      chk($sformatf("tbl g1 r%0d", k), 32'(grant_o[2]), 32'(tbl[k].g1));
    end

    // Owner 1 drops while 0 and 3 raise at the same edge: search from 2 finds 3.
    do_reset();
    for (int k = 0; k < 3; k++) step(4'b0010);
    chk("own1 grant", 32'(grant_o[0]), 32'h2);
    step(4'b1001);
    for (int i = 0; i < 3; i++)
      chk($sformatf("handover to 3 mh=%0d", mhv[i]), 32'(grant_o[i]), 32'h8);
    for (int k = 0; k < 7; k++) step(4'b1001);
    chk("src3 last cycle", 32'(ol_o[0]), 32'h1);
    step(4'b1001);
    chk("handover to 0", 32'(grant_o[0]), 32'h1);

    // One-cycle request pulse, then idle with sel held.
    do_reset();
    step(4'b0100);
    chk("pulse grant", 32'(grant_o[0]), 32'h4);
    step(4'b0000);
    chk("pulse idle grant", 32'(grant_o[0]), 32'h0);
    chk("pulse idle valid", 32'(bv_o[0]), 32'h0);
    chk("pulse idle sel", 32'(sel_o[0]), 32'h2);
    step(4'b0000);

    // Forced rotation every cycle with hold limit 1.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      step(4'b0011);
      chk($sformatf("mh1 alt c%0d", k), 32'(grant_o[2]), (k % 2 == 0) ? 32'h1 : 32'h2);
      chk($sformatf("mh1 last c%0d", k), 32'(ol_o[2]), 32'h1);
    end

    // Asynchronous reset mid-ownership (owner 2, hold_cnt 3).
    do_reset();
    for (int k = 0; k < 4; k++) step(4'b0100);
    chk("pre-reset grant", 32'(grant_o[0]), 32'h4);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async rst grant", 32'(grant_o[0]), 32'h0);
    chk("async rst sel", 32'(sel_o[0]), 32'h0);
    chk("async rst valid", 32'(bv_o[0]), 32'h0);
    chk("async rst last", 32'(ol_o[0]), 32'h0);
    req = 4'b1111;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b1111);
    chk("post-reset grant", 32'(grant_o[0]), 32'h1);

    // Random traffic, requests tend to persist for a few cycles.
    do_reset();
    begin
      logic [3:0] r;
      r = 4'b0000;
      for (int k = 0; k < 400; k++) begin
        if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
        else if ($urandom_range(0, 3) == 0) r[$urandom_range(0, 3)] = ~r[$urandom_range(0, 3)];
        step(r);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
